// File: rtl/sr_flip_flop_if.sv
// Bundles the per-bit set/clear requests and the registered state outputs
// of an SR flip-flop bank.
interface sr_flip_flop_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] invalid;

  modport master (
    output s,
    output r,
    input  q,
    input  qn,
    input  invalid
  );

  modport slave (
    input  s,
    input  r,
    output q,
    output qn,
    output invalid
  );
endinterface

// File: rtl/sr_flip_flop.sv
// Bank of independent clocked SR flip-flops with a configurable response to
// the forbidden s=r=1 input and a registered per-bit flag reporting it.
module sr_flip_flop #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      BOTH_MODE = 0
) (
  input  logic           clk,
  input  logic           reset,
  sr_flip_flop_if.slave  bus
);

  localparam logic [1:0] MODE_HOLD  = 2'd0;
  localparam logic [1:0] MODE_SET   = 2'd1;
  localparam logic [1:0] MODE_RESET = 2'd2;
  localparam logic [1:0] MODE_TOG   = 2'd3;

  // Unsupported mode encodings fall back to hold.
  localparam logic [1:0] MODE_EFF = (BOTH_MODE <= 32'd3) ? BOTH_MODE[1:0] : MODE_HOLD;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_invalid;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_invalid_next;

  function automatic logic resolve_bit(input logic q_cur, input logic s_in, input logic r_in);
    logic nxt;
    case ({s_in, r_in})
      2'b00: nxt = q_cur;
      2'b10: nxt = 1'b1;
      2'b01: nxt = 1'b0;
      2'b11: begin
        case (MODE_EFF)
          MODE_SET:   nxt = 1'b1;
          MODE_RESET: nxt = 1'b0;
          MODE_TOG:   nxt = ~q_cur;
          default:    nxt = q_cur;
        endcase
      end
      default: nxt = q_cur;
    endcase
    return nxt;
  endfunction

  // Per-bit next state and forbidden-input flag.
  always_comb begin
    w_q_next       = r_q;
    w_invalid_next = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_q_next[i]       = resolve_bit(r_q[i], bus.s[i], bus.r[i]);
      w_invalid_next[i] = bus.s[i] & bus.r[i];
    end
  end

  // State and flag registers; reset outranks any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q       <= RESET_VAL;
      r_invalid <= '0;
    end else begin
      r_q       <= w_q_next;
      r_invalid <= w_invalid_next;
    end
  end

  assign bus.q       = r_q;
  assign bus.qn      = ~r_q;
  assign bus.invalid = r_invalid;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Scoreboard bench: stimulus pushes expected post-edge values, a monitor
// pops and compares them just after each rising edge.
module tb_sr_flip_flop;

  logic clk;
  logic reset;

  sr_flip_flop_if #(.WIDTH(1)) if0 ();
  sr_flip_flop_if #(.WIDTH(1)) if1 ();
  sr_flip_flop_if #(.WIDTH(1)) if2 ();
  sr_flip_flop_if #(.WIDTH(1)) if3 ();
  sr_flip_flop_if #(.WIDTH(4)) if4 ();

  sr_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0), .BOTH_MODE(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  sr_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0), .BOTH_MODE(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  sr_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0), .BOTH_MODE(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));
  sr_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0), .BOTH_MODE(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));
  sr_flip_flop #(.WIDTH(4), .RESET_VAL(4'b1010), .BOTH_MODE(0)) dut4 (.clk(clk), .reset(reset), .bus(if4));

  typedef struct {
    int         tgt;
    int         id;
    logic [3:0] q;
    logic [3:0] qn;
    logic [3:0] inv;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void get_act(input int id, output logic [3:0] q, output logic [3:0] qn,
                                  output logic [3:0] inv);
    case (id)
      0:       begin q = {3'b000, if0.q}; qn = {3'b000, if0.qn}; inv = {3'b000, if0.invalid}; end
      1:       begin q = {3'b000, if1.q}; qn = {3'b000, if1.qn}; inv = {3'b000, if1.invalid}; end
      2:       begin q = {3'b000, if2.q}; qn = {3'b000, if2.qn}; inv = {3'b000, if2.invalid}; end
      3:       begin q = {3'b000, if3.q}; qn = {3'b000, if3.qn}; inv = {3'b000, if3.invalid}; end
      default: begin q = if4.q; qn = if4.qn; inv = if4.invalid; end
    endcase
  endfunction

  // Monitor: every DUT presents fresh outputs after each rising edge.
  initial begin
    exp_t       e;
    logic [3:0] aq, aqn, ainv;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      while (sb.size() > 0 && sb[0].tgt <= cyc) begin
        e = sb.pop_front();
        get_act(e.id, aq, aqn, ainv);
        n_tests++;
        if (aq !== e.q || aqn !== e.qn || ainv !== e.inv) begin
          n_fail++;
          $display("FAIL %s dut%0d: got q=%b qn=%b inv=%b, expected q=%b qn=%b inv=%b",
                   e.name, e.id, aq, aqn, ainv, e.q, e.qn, e.inv);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic s1, input logic r1,
                      input logic [3:0] s4, input logic [3:0] r4);
    @(negedge clk);
    reset = rst;
    if0.s = s1; if0.r = r1;
    if1.s = s1; if1.r = r1;
    if2.s = s1; if2.r = r1;
    if3.s = s1; if3.r = r1;
    if4.s = s4; if4.r = r4;
  endtask

  task automatic exp1(input int id, input logic q, input logic inv, input string nm);
    exp_t e;
    e.tgt = cyc + 1; e.id = id; e.name = nm;
    e.q = {3'b000, q}; e.qn = {3'b000, ~q}; e.inv = {3'b000, inv};
    sb.push_back(e);
  endtask

  task automatic exp_all(input logic q, input logic inv, input string nm);
    for (int k = 0; k < 4; k++) exp1(k, q, inv, nm);
  endtask

  task automatic exp4(input logic [3:0] q, input logic [3:0] inv, input string nm);
    exp_t e;
    e.tgt = cyc + 1; e.id = 4; e.name = nm;
    e.q = q; e.qn = ~q; e.inv = inv;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    if0.s = 1'b0; if0.r = 1'b0;
    if1.s = 1'b0; if1.r = 1'b0;
    if2.s = 1'b0; if2.r = 1'b0;
    if3.s = 1'b0; if3.r = 1'b0;
    if4.s = 4'b0000; if4.r = 4'b0000;

    step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000); exp_all(1'b0, 1'b0, "rst_a"); exp4(4'b1010, 4'b0000, "rst4_a");
    step(1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000); exp_all(1'b0, 1'b0, "rst_b"); exp4(4'b1010, 4'b0000, "rst4_b");
    step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000); exp_all(1'b0, 1'b0, "idle_a"); exp4(4'b1010, 4'b0000, "idle4");
    step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000); exp_all(1'b0, 1'b0, "idle_b");

    // Width/independence on the 4-bit bank.
    step(1'b0, 1'b0, 1'b0, 4'b0101, 4'b1000); exp4(4'b0111, 4'b0000, "w4_set_clr");
    step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000); exp4(4'b0111, 4'b0000, "w4_hold");
    step(1'b0, 1'b0, 1'b0, 4'b1100, 4'b0100); exp4(4'b1111, 4'b0100, "w4_both");
    step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000); exp4(4'b1111, 4'b0000, "w4_inv_clr");

    // Set / clear / hold.
    step(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000); exp_all(1'b1, 1'b0, "set");
    step(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000); exp_all(1'b0, 1'b0, "clr");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000); exp_all(1'b0, 1'b0, "hold0");
    end
    step(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000); exp_all(1'b1, 1'b0, "set2");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000); exp_all(1'b1, 1'b0, "hold1");
    end

    // Reset outranks set; release with set still high.
    step(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000); exp_all(1'b0, 1'b0, "rst_prio"); exp4(4'b1010, 4'b0000, "rst4_prio");
    step(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000); exp_all(1'b1, 1'b0, "rst_release");

    // Forbidden s=r=1 from q=1 on each mode.
    step(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
    exp1(0, 1'b1, 1'b1, "both_m0"); exp1(1, 1'b1, 1'b1, "both_m1");
    exp1(2, 1'b0, 1'b1, "both_m2"); exp1(3, 1'b0, 1'b1, "both_m3");
    step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    exp1(0, 1'b1, 1'b0, "after_m0"); exp1(1, 1'b1, 1'b0, "after_m1");
    exp1(2, 1'b0, 1'b0, "after_m2"); exp1(3, 1'b0, 1'b0, "after_m3");
    step(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
    exp1(0, 1'b1, 1'b1, "both2_m0"); exp1(1, 1'b1, 1'b1, "both2_m1");
    exp1(2, 1'b0, 1'b1, "both2_m2"); exp1(3, 1'b1, 1'b1, "both2_m3");
    step(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
    exp1(0, 1'b1, 1'b1, "both3_m0"); exp1(1, 1'b1, 1'b1, "both3_m1");
    exp1(2, 1'b0, 1'b1, "both3_m2"); exp1(3, 1'b0, 1'b1, "both3_m3");
    step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    exp1(0, 1'b1, 1'b0, "end_m0"); exp1(1, 1'b1, 1'b0, "end_m1");
    exp1(2, 1'b0, 1'b0, "end_m2"); exp1(3, 1'b0, 1'b0, "end_m3");

    // A set pulse strictly between edges must never be sampled.
    step(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000); exp_all(1'b0, 1'b0, "clr_pre_pulse");
    step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000); exp_all(1'b0, 1'b0, "pulse_a"); exp4(4'b1010, 4'b0000, "pulse4");
    #1;
    if0.s = 1'b1; if1.s = 1'b1; if2.s = 1'b1; if3.s = 1'b1; if4.s = 4'b1111;
    #3;
    if0.s = 1'b0; if1.s = 1'b0; if2.s = 1'b0; if3.s = 1'b0; if4.s = 4'b0000;
    step(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000); exp_all(1'b0, 1'b0, "pulse_b"); exp4(4'b1010, 4'b0000, "pulse4_b");

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
